// File: rtl/cache_6502_pkg.sv
// Shared types and helpers for the 6502 N-way read cache.
package cache_6502_pkg;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    MEM_WAIT = 2'd1,
    FILL     = 2'd2
  } State_Type;

  // Picks the upper address byte: fetches use upai, page 0/1 use upazo.
  function automatic logic [7:0] sel_upa(input logic       iread,
                                         input logic [6:0] addr_hi,
                                         input logic [7:0] upad,
                                         input logic [7:0] upai,
                                         input logic [7:0] upazo);
    if (iread) return upai;
    if (addr_hi == 7'd0) return upazo;
    return upad;
  endfunction

endpackage

// File: rtl/cache_line_nway.sv
// One fully-associative cache line: tag, valid bit and byte array.
module cache_line_nway #(
  parameter int LINE_BYTES = 8,
  parameter int OFF_W      = 3,
  parameter int TAG_W      = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic [OFF_W-1:0] lookup_off,
  output logic             hit,
  output logic [7:0]       rdata,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             fill_we,
  input  logic [OFF_W-1:0] fill_off,
  input  logic [7:0]       fill_data,
  input  logic             set_valid,
  input  logic             upd_en,
  input  logic [7:0]       upd_data
);

  logic                       valid;
  logic [TAG_W-1:0]           tag_q;
  logic [LINE_BYTES-1:0][7:0] data;

  assign hit   = valid && (tag_q == lookup_tag);
  assign rdata = data[lookup_off];

  // Retagging keeps the line invalid until its fill completes.
  always_ff @(posedge clk) begin
    if (rst || flush)   valid <= 1'b0;
    else if (tag_we)    valid <= 1'b0;
    else if (set_valid) valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         tag_q <= '0;
    else if (tag_we) tag_q <= tag_in;
  end

  always_ff @(posedge clk) begin
    if (fill_we)            data[fill_off]   <= fill_data;
    else if (upd_en && hit) data[lookup_off] <= upd_data;
  end

endmodule

// File: rtl/cache_6502_nway.sv
// N-way fully-associative read cache between the 6502 core and memory.
module cache_6502_nway
  import cache_6502_pkg::*;
#(
  parameter int NUM_LINES  = 4,
  parameter int LINE_BYTES = 8,
  parameter int OFF_W      = $clog2(LINE_BYTES),
  parameter int TAG_W      = 24 - OFF_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_en,
  input  logic        dcache_en,
  input  logic        flush,
  input  logic        skip_int,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_en,
  input  logic        cpu_wr,
  input  logic        cpu_iread,
  input  logic        cpu_nocache,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rdata,
  input  logic        int_en,
  input  logic [7:0]  int_rdata,
  input  logic [7:0]  upad,
  input  logic [7:0]  upai,
  input  logic [7:0]  upazo,
  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic        mem_rburst,
  output logic        mem_wburst,
  output logic [7:0]  mem_wdata,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_rdata,
  input  logic [7:0]  mem_rdata0,
  input  logic        mem_rdata_load
);

  localparam int VIC_W = $clog2(NUM_LINES);

  State_Type        state;
  logic [VIC_W-1:0] victim;
  logic [OFF_W-1:0] fill_off, save_off;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_kill;

  logic [23:0]      fa;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off;
  logic             cacheable, in_ready, idle_skip, rd_hit, rd_miss, bypass, wr_upd, last_beat;

  logic [NUM_LINES-1:0]      hit_vec;
  logic [NUM_LINES-1:0][7:0] rd_vec;
  logic                      any_hit;
  logic [7:0]                hit_byte;

  // Memory handshake outputs that this cache never consumes.
  logic unused_mem;
  assign unused_mem = ^{mem_rdy, mem_rdata};

  assign fa  = {sel_upa(cpu_iread, cpu_addr[15:9], upad, upai, upazo), cpu_addr};
  assign tag = fa[23:OFF_W];
  assign off = fa[OFF_W-1:0];

  assign cacheable = !cpu_wr && !cpu_nocache && (cpu_iread ? icache_en : dcache_en);
  assign in_ready  = (state == READY);
  assign idle_skip = !cpu_en && skip_int;
  assign rd_hit    = in_ready && !idle_skip && !int_en && cacheable && any_hit;
  assign rd_miss   = in_ready && !idle_skip && !int_en && cacheable && !any_hit;
  assign bypass    = in_ready && !idle_skip && !int_en && !cacheable;
  assign wr_upd    = bypass && cpu_wr;
  assign last_beat = (state == FILL) && mem_rdata_load && (fill_off == OFF_W'(LINE_BYTES - 1));

  // Lowest matching index wins; more than one match is never expected.
  always_comb begin
    any_hit  = 1'b0;
    hit_byte = 8'h00;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        hit_byte = rd_vec[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    cache_line_nway #(
      .LINE_BYTES(LINE_BYTES), .OFF_W(OFF_W), .TAG_W(TAG_W)
    ) u_line (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .lookup_tag(tag),
      .lookup_off(off),
      .hit       (hit_vec[i]),
      .rdata     (rd_vec[i]),
      .tag_we    (rd_miss && (victim == VIC_W'(i))),
      .tag_in    (tag),
      .fill_we   ((state == FILL) && mem_rdata_load && (victim == VIC_W'(i))),
      .fill_off  (fill_off),
      .fill_data (mem_rdata0),
      .set_valid (last_beat && (victim == VIC_W'(i)) && !fill_kill && !flush),
      .upd_en    (wr_upd),
      .upd_data  (cpu_wdata)
    );
  end

  assign cpu_rdy    = in_ready;
  assign mem_en     = rd_miss || bypass || !in_ready;
  assign mem_rburst = rd_miss || (state == FILL);
  assign mem_addr   = (state == FILL) ? {fill_tag, {OFF_W{1'b0}}} :
                      rd_miss         ? {tag, {OFF_W{1'b0}}}      : fa;
  assign mem_wr     = cpu_wr;
  assign mem_wdata  = cpu_wdata;
  assign mem_wburst = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= READY;
      cpu_rdata <= 8'h00;
      victim    <= '0;
      fill_off  <= '0;
      save_off  <= '0;
      fill_tag  <= '0;
      fill_kill <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (!idle_skip) begin
            if (int_en) cpu_rdata <= int_rdata;
            else if (rd_hit) cpu_rdata <= hit_byte;
            else if (rd_miss) begin
              save_off  <= off;
              fill_tag  <= tag;
              fill_off  <= '0;
              fill_kill <= flush;
              state     <= FILL;
            end else state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_rdata_load) begin
            cpu_rdata <= mem_rdata0;
            state     <= READY;
          end
        end
        FILL: begin
          if (flush) fill_kill <= 1'b1;
          if (mem_rdata_load) begin
            fill_off <= fill_off + OFF_W'(1);
            // Critical byte is captured as it streams past.
            if (fill_off == save_off) cpu_rdata <= mem_rdata0;
            if (last_beat) begin
              victim <= victim + VIC_W'(1);
              state  <= READY;
            end
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_6502_nway.sv
// Directed bench for cache_6502_nway (4 lines x 8 bytes).
module tb_cache_6502_nway;

  localparam int LB = 8;

  logic        clk = 1'b0;
  logic        rst, icache_en, dcache_en, flush, skip_int;
  logic [15:0] cpu_addr;
  logic        cpu_en, cpu_wr, cpu_iread, cpu_nocache;
  logic [7:0]  cpu_wdata, cpu_rdata, int_rdata, upad, upai, upazo;
  logic        cpu_rdy, int_en;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr, mem_rburst, mem_wburst, mem_rdy, mem_rdata_load;
  logic [7:0]  mem_wdata, mem_rdata, mem_rdata0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_6502_nway #(.NUM_LINES(4), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst(rst), .icache_en(icache_en), .dcache_en(dcache_en), .flush(flush),
    .skip_int(skip_int), .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_wr(cpu_wr),
    .cpu_iread(cpu_iread), .cpu_nocache(cpu_nocache), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata), .int_en(int_en), .int_rdata(int_rdata),
    .upad(upad), .upai(upai), .upazo(upazo), .mem_addr(mem_addr), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem_rburst(mem_rburst), .mem_wburst(mem_wburst),
    .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .mem_rdata0(mem_rdata0), .mem_rdata_load(mem_rdata_load)
  );

  // Backing-store contents seen by the cache.
  function automatic logic [7:0] mb(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0)
      assert ($countones(dut.hit_vec) <= 1) else begin
        n_fail++;
        $error("FAIL multi_hit: observed %b expected at most one bit", dut.hit_vec);
      end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_en = 1'b0; cpu_wr = 1'b0; cpu_iread = 1'b0; cpu_nocache = 1'b0; skip_int = 1'b1;
  endtask

  task automatic access(input logic iread, input logic [15:0] a);
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_iread = iread; cpu_addr = a; skip_int = 1'b0;
  endtask

  task automatic do_fill(input logic [23:0] base, input int crit, input int flush_at);
    for (int k = 0; k < LB; k++) begin
      mem_rdata_load = 1'b1;
      mem_rdata0     = mb(base + 24'(k));
      flush          = (k == flush_at);
      if (k == 0) begin
        chk("fill_burst", {31'd0, mem_en & mem_rburst}, 32'd1);
        chk("fill_addr", {8'd0, mem_addr}, {8'd0, base});
        chk("fill_rdy", {31'd0, cpu_rdy}, 32'd0);
      end
      tick();
      if (k == crit) chk("crit_byte", {24'd0, cpu_rdata}, {24'd0, mb(base + 24'(crit))});
    end
    mem_rdata_load = 1'b0;
    flush = 1'b0;
    idle();
    chk("fill_done_rdy", {31'd0, cpu_rdy}, 32'd1);
  endtask

  task automatic miss(input logic iread, input logic [15:0] a, input logic [23:0] base,
                      input int crit, input int flush_at);
    access(iread, a);
    #1;
    chk("miss_rburst", {31'd0, mem_rburst}, 32'd1);
    chk("miss_addr", {8'd0, mem_addr}, {8'd0, base});
    tick();
    do_fill(base, crit, flush_at);
  endtask

  task automatic hit(input logic iread, input logic [15:0] a, input logic [7:0] exp);
    access(iread, a);
    #1;
    chk("hit_no_mem", {31'd0, mem_en}, 32'd0);
    tick();
    chk("hit_data", {24'd0, cpu_rdata}, {24'd0, exp});
    idle();
  endtask

  // Combinational look without committing: inputs are withdrawn before the edge.
  task automatic probe(input logic iread, input logic [15:0] a, input string tag,
                       input logic exp_en, input logic exp_burst);
    access(iread, a);
    #1;
    chk({tag, "_en"}, {31'd0, mem_en}, {31'd0, exp_en});
    chk({tag, "_burst"}, {31'd0, mem_rburst}, {31'd0, exp_burst});
    idle();
  endtask

  initial begin
    rst = 1'b1; icache_en = 1'b0; dcache_en = 1'b0; flush = 1'b0;
    cpu_addr = 16'h0; cpu_wdata = 8'h0; int_en = 1'b0; int_rdata = 8'h0;
    upad = 8'h00; upai = 8'h00; upazo = 8'h00;
    mem_rdy = 1'b0; mem_rdata = 8'h0; mem_rdata0 = 8'h0; mem_rdata_load = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_rburst", {31'd0, mem_rburst}, 32'd0);
    chk("rst_wburst", {31'd0, mem_wburst}, 32'd0);

    // 1: ifetch miss at 1234, critical byte on beat 5, then the whole line hits
    icache_en = 1'b1;
    miss(1'b1, 16'h1234, 24'h001230, 4, -1);
    for (int i = 0; i < LB; i++) hit(1'b1, 16'h1230 + 16'(i), mb(24'h001230 + 24'(i)));

    // 2: five fills in a four-line cache evict the first tag only
    rst = 1'b1; tick(); rst = 1'b0;
    probe(1'b1, 16'h1234, "rst_inval", 1'b1, 1'b1);
    miss(1'b1, 16'h1001, 24'h001000, 1, -1);
    miss(1'b1, 16'h1102, 24'h001100, 2, -1);
    miss(1'b1, 16'h1203, 24'h001200, 3, -1);
    miss(1'b1, 16'h1307, 24'h001300, 7, -1);
    miss(1'b1, 16'h1400, 24'h001400, 0, -1);
    probe(1'b1, 16'h1000, "evicted", 1'b1, 1'b1);
    hit(1'b1, 16'h1105, mb(24'h001105));
    hit(1'b1, 16'h1206, mb(24'h001206));
    hit(1'b1, 16'h1301, mb(24'h001301));
    miss(1'b1, 16'h1000, 24'h001000, 0, -1);

    // 3: write hit goes to memory and updates the cached byte
    cpu_en = 1'b1; cpu_wr = 1'b1; cpu_iread = 1'b0; skip_int = 1'b0;
    cpu_addr = 16'h1302; cpu_wdata = 8'hA5;
    #1;
    chk("wr_mem_en", {31'd0, mem_en}, 32'd1);
    chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr_wdata", {24'd0, mem_wdata}, 32'h0000_00A5);
    chk("wr_addr", {8'd0, mem_addr}, 32'h0000_1302);
    tick();
    chk("wr_wait_rdy", {31'd0, cpu_rdy}, 32'd0);
    cpu_wr = 1'b0; mem_rdata_load = 1'b1; mem_rdata0 = 8'h00;
    tick();
    mem_rdata_load = 1'b0;
    idle();
    chk("wr_done_rdy", {31'd0, cpu_rdy}, 32'd1);
    hit(1'b1, 16'h1302, 8'hA5);

    // 4: same cpu_addr in two data banks gives two lines
    dcache_en = 1'b1; upad = 8'h01;
    miss(1'b0, 16'h2000, 24'h012000, 0, -1);
    upad = 8'h02;
    miss(1'b0, 16'h2000, 24'h022000, 0, -1);
    upad = 8'h01;
    hit(1'b0, 16'h2000, 8'h7B);
    upad = 8'h02;
    hit(1'b0, 16'h2000, 8'h78);

    // 5: flush mid-fill still delivers the byte; everything misses afterwards
    miss(1'b1, 16'h1506, 24'h001500, 6, 3);
    chk("flush_byte", {24'd0, cpu_rdata}, {24'd0, mb(24'h001506)});
    probe(1'b1, 16'h1500, "flush_line", 1'b1, 1'b1);
    upad = 8'h01;
    probe(1'b0, 16'h2000, "flush_other", 1'b1, 1'b1);
    upad = 8'h00;

    // 6: disabled class and nocache bypass a cached line; reset mid-fill
    miss(1'b1, 16'h1600, 24'h001600, 0, -1);
    icache_en = 1'b0;
    probe(1'b1, 16'h1600, "icache_off", 1'b1, 1'b0);
    icache_en = 1'b1;
    probe(1'b1, 16'h1600, "icache_back", 1'b0, 1'b0);
    access(1'b1, 16'h1600);
    cpu_nocache = 1'b1;
    #1;
    chk("nc_mem_en", {31'd0, mem_en}, 32'd1);
    chk("nc_rburst", {31'd0, mem_rburst}, 32'd0);
    chk("nc_addr", {8'd0, mem_addr}, 32'h0000_1600);
    tick();
    chk("nc_wait_rdy", {31'd0, cpu_rdy}, 32'd0);
    mem_rdata_load = 1'b1; mem_rdata0 = 8'h42;
    tick();
    mem_rdata_load = 1'b0;
    idle();
    chk("nc_data", {24'd0, cpu_rdata}, 32'h0000_0042);

    access(1'b1, 16'h1700);
    tick();
    mem_rdata_load = 1'b1; mem_rdata0 = mb(24'h001700);
    tick(); tick();
    mem_rdata_load = 1'b0;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    chk("rstfill_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("rstfill_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rstfill_rburst", {31'd0, mem_rburst}, 32'd0);
    chk("rstfill_rdata", {24'd0, cpu_rdata}, 32'd0);
    probe(1'b1, 16'h1600, "rstfill_inval", 1'b1, 1'b1);
    miss(1'b1, 16'h1703, 24'h001700, 3, -1);
    hit(1'b1, 16'h1707, mb(24'h001707));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_6502_nway.md
Name: cache_6502_nway

Overview:
- Parametrised N-way fully-associative read cache between the 6502 core and the external memory port. Successor to the fixed 2-line, 8-byte instruction cache.
- Adds configurable line count and line size, and optional data-read caching.
- Full 24-bit tags, so bank/page switching via the upper address byte never aliases.
- Adds write-hit update (write-through), a flush input and an uncacheable-access input.

Parameters:
- NUM_LINES, 4, number of lines; power of two, 2..16.
- LINE_BYTES, 8, bytes per line; power of two, 4..32.
- OFF_W, $clog2(LINE_BYTES), derived; do not override.
- TAG_W, 24-OFF_W, derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_en  in  1  enable caching of instruction fetches
- dcache_en  in  1  enable caching of data reads
- flush  in  1  invalidate all lines (single-cycle pulse)
- skip_int  in  1  allow idle cycles to complete without memory access
- cpu_addr  in  16  CPU address
- cpu_en  in  1  CPU access request
- cpu_wr  in  1  write
- cpu_iread  in  1  instruction fetch
- cpu_nocache  in  1  current access is uncacheable (I/O decode)
- cpu_wdata  in  8  write data
- cpu_rdy  out  1  access completes this cycle
- cpu_rdata  out  8  registered read data
- int_en  in  1  internal memory hit
- int_rdata  in  8  internal memory data
- upad  in  8  upper address byte, data accesses
- upai  in  8  upper address byte, instruction accesses
- upazo  in  8  upper address byte, zero page and stack accesses
- mem_addr  out  24  memory address
- mem_en  out  1  memory request
- mem_wr  out  1  memory write
- mem_rburst  out  1  read burst active
- mem_wburst  out  1  tied 0
- mem_wdata  out  8  memory write data
- mem_rdy  in  1  memory ready
- mem_rdata  in  8  memory read data
- mem_rdata0  in  8  early read data
- mem_rdata_load  in  1  mem_rdata0 valid this cycle

Behaviour:
- Reset is synchronous, active-high, from rst: state=READY, cpu_rdy=1, cpu_rdata=8'h00, mem_en=0, mem_rburst=0, all valid bits 0, victim pointer 0, fill counter 0.
- Upper address byte (upa) selection: upai if cpu_iread; else upazo if cpu_addr[15:9]==0; else upad.
- Full address: fa = {upa, cpu_addr}. Tag = fa[23:OFF_W].
- Cacheable access: !cpu_wr && !cpu_nocache && ((cpu_iread && icache_en) || (!cpu_iread && dcache_en)).

READY state; cpu_rdy=1. Priority, highest first:
1. !cpu_en && skip_int: stay in READY.
2. int_en: latch int_rdata into cpu_rdata.
3. Cacheable access and hit: latch the hit byte into cpu_rdata. Zero-wait.
4. Cacheable access and miss: mem_addr = {fa[23:OFF_W], 0}. Save fa[OFF_W-1:0]. Tag the victim line, keeping it invalid. Go to FILL.
5. Otherwise (write, uncacheable, or cache disabled): mem_en=1. Go to MEM_WAIT.

- Write hit: if cpu_wr and any valid line tag matches fa (regardless of the enables), that byte is updated with cpu_wdata in the issue cycle. The write always also goes to memory.

MEM_WAIT:
- mem_en=1.
- On mem_rdata_load: latch mem_rdata0 into cpu_rdata and go to READY.

FILL:
- mem_en=mem_rburst=1 until the last beat.
- Each mem_rdata_load writes mem_rdata0 to line[victim][fill_off] and increments fill_off.
- When fill_off equals the saved offset, the byte is also latched into cpu_rdata (critical byte captured as it streams past).
- On the last beat (fill_off==LINE_BYTES-1): set valid, advance victim = (victim+1) mod NUM_LINES, go to READY.

Flush, and disabling a cache:
- flush clears all valid bits at the next edge, in any state.
- If flush arrives during FILL, the burst still completes and the CPU still gets its byte, but the line stays invalid.
- Dropping icache_en or dcache_en does not invalidate lines. Disabled classes simply bypass the cache.

Simultaneous events:
- At most one line may match. Multiple matches are a design error; the bench asserts this, and the lowest index wins.
- A hit and a fill to the same tag cannot coexist because the filling line is invalid.

Other outputs:
- cpu_rdy=0 in MEM_WAIT and FILL.
- mem_wr=cpu_wr, mem_wdata=cpu_wdata, mem_wburst=0.

Decomposition:
- Shared package cache_6502_pkg: State_Type enum (READY, MEM_WAIT, FILL) and the upa selection function.
- Sub-module cache_line_nway, one per line, generated NUM_LINES times. It holds the tag, valid bit and LINE_BYTES×8 data array. Its ports are lookup hit/rdata, fill write, write-hit update and flush.

Test Plan:
1. Ifetch miss at 16'h1234, upai=8'h00, NUM_LINES=4, LINE_BYTES=8 -> burst reads 24'h001230..37. cpu_rdata equals the byte at 1234, latched on the 5th beat. A refetch of 1230..1237 then hits with zero wait and mem_en=0.
2. Fill 5 distinct lines in a 4-line cache -> the 5th fill evicts line 0 (first tag). The refetch misses; the other three still hit.
3. Write 8'hA5 to a cached byte -> the memory write is issued, and the next read of that byte hits and returns 8'hA5.
4. Same cpu_addr 16'h2000 with upad=8'h01, then upad=8'h02, dcache_en=1 -> two separate misses and two separate lines, no aliasing.
5. Assert flush mid-FILL -> the CPU receives the correct byte, and the next fetch of the same line misses.
6. Read with cpu_nocache=1 at a cached address -> MEM_WAIT is taken and no cache hit; rst during FILL -> READY, mem_en=0 and all lines invalid on the next cycle.
